// File: rtl/i2c_master_writer.sv
// Single-shot I2C write master: START, 7-bit address + W, ACK, 32 data bits MSB-first, ACK, STOP.
// Both lines are open-drain; SDA is read back through a 2-flop synchronizer for the ACK slots.
module i2c_master_writer #(
  parameter logic [6:0] SLAVE_ADDR = 7'b0101010,
  parameter int         CLK_DIV    = 250
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] data_in,
  output logic        busy,
  output logic        done,
  output logic        ack_err,
  inout  wire         i2c_scl,
  inout  wire         i2c_sda
);

  localparam int              CNT_W     = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLK_DIV - 1);
  localparam logic [7:0]      ADDR_BYTE = {SLAVE_ADDR, 1'b0};

  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_ADDR, ST_ACK1, ST_DATA, ST_ACK2, ST_STOP, ST_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        qtr_q, qtr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [5:0]        bit_q, bit_d;
  logic [31:0]       shift_q, shift_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              ack_err_q, ack_err_d;
  logic              scl_low_q, scl_low_d;
  logic              sda_low_q, sda_low_d;
  logic              sda_meta_q, sda_sync_q;

  // DONE behaves like IDLE for acceptance so back-to-back requests lose no cycle.
  always_comb begin
    state_d   = state_q;
    qtr_d     = qtr_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    ack_err_d = ack_err_q;
    if (state_q == ST_IDLE || state_q == ST_DONE) begin
      state_d = ST_IDLE;
      if (start) begin
        state_d   = ST_START;
        qtr_d     = 2'd0;
        cnt_d     = '0;
        bit_d     = 6'd0;
        shift_d   = data_in;
        busy_d    = 1'b1;
        ack_err_d = 1'b0;
      end
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = '0;
      qtr_d = qtr_q + 2'd1;
      case (state_q)
        ST_START: begin
          if (qtr_q == 2'd1) begin
            state_d = ST_ADDR;
            qtr_d   = 2'd0;
          end
        end
        ST_ADDR: begin
          if (qtr_q == 2'd3) begin
            if (bit_q == 6'd7) begin
              state_d = ST_ACK1;
              bit_d   = 6'd0;
            end else begin
              bit_d = bit_q + 6'd1;
            end
          end
        end
        ST_ACK1: begin
          if (qtr_q == 2'd3) begin
            if (sda_sync_q) begin
              ack_err_d = 1'b1;
              state_d   = ST_STOP;
            end else begin
              state_d = ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (qtr_q == 2'd3) begin
            shift_d = {shift_q[30:0], 1'b0};
            if (bit_q == 6'd31) begin
              state_d = ST_ACK2;
              bit_d   = 6'd0;
            end else begin
              bit_d = bit_q + 6'd1;
            end
          end
        end
        ST_ACK2: begin
          if (qtr_q == 2'd3) begin
            ack_err_d = sda_sync_q;
            state_d   = ST_STOP;
          end
        end
        ST_STOP: begin
          if (qtr_q == 2'd3) begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
        default: ;
      endcase
    end

    // Line levels are a function of the upcoming state/quarter so they can be registered.
    scl_low_d = 1'b0;
    sda_low_d = 1'b0;
    case (state_d)
      ST_START: sda_low_d = 1'b1;
      ST_ADDR: begin
        scl_low_d = ~qtr_d[1];
        sda_low_d = ~ADDR_BYTE[3'd7 - bit_d[2:0]];
      end
      ST_ACK1, ST_ACK2: scl_low_d = ~qtr_d[1];
      ST_DATA: begin
        scl_low_d = ~qtr_d[1];
        sda_low_d = ~shift_d[31];
      end
      ST_STOP: begin
        scl_low_d = (qtr_d == 2'd0);
        sda_low_d = ~qtr_d[1];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      qtr_q      <= 2'd0;
      cnt_q      <= '0;
      bit_q      <= 6'd0;
      shift_q    <= 32'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ack_err_q  <= 1'b0;
      scl_low_q  <= 1'b0;
      sda_low_q  <= 1'b0;
      sda_meta_q <= 1'b1;
      sda_sync_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      qtr_q      <= qtr_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ack_err_q  <= ack_err_d;
      scl_low_q  <= scl_low_d;
      sda_low_q  <= sda_low_d;
      sda_meta_q <= i2c_sda;
      sda_sync_q <= sda_meta_q;
    end
  end

  assign i2c_scl = scl_low_q ? 1'b0 : 1'bz;
  assign i2c_sda = sda_low_q ? 1'b0 : 1'bz;
  assign busy    = busy_q;
  assign done    = done_q;
  assign ack_err = ack_err_q;

endmodule

// File: tb/tb_i2c_master_writer.sv
// Bench for i2c_master_writer: a clock-sampled bus monitor/ACK model decodes every frame,
// and each transaction is checked against latency, frame contents and status from first principles.
module tb_i2c_master_writer;

  localparam int         CLK_DIV  = 2;
  localparam logic [6:0] ADDR     = 7'b0101010;
  localparam int         LAT_FULL = 1 + 174 * CLK_DIV;
  localparam int         LAT_ABRT = 1 + 42 * CLK_DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] dataIn = 32'd0;
  logic        busy, done, ackErr;
  wire         sclW, sdaW;
  logic        pull = 1'b0;

  int nVec = 0;
  int nErr = 0;
  int cyc = 0;

  // Bus monitor / slave ACK model state (written only by the monitor process).
  bit          ack1En = 1'b1;
  bit          ack2En = 1'b1;
  logic        prevScl = 1'b1, prevSda = 1'b1, prevBusy = 1'b0;
  bit          inFrame = 1'b0;
  int          bitRises = 0;
  logic [63:0] curWord = 64'd0;
  int          curLen = 0;
  logic [63:0] lastWord = 64'd0;
  int          lastLen = 0;
  int          frameCount = 0, startCount = 0, overlapCount = 0, doneCount = 0;
  int          busyRiseCyc = 0;

  pullup (sclW);
  pullup (sdaW);
  assign sdaW = pull ? 1'b0 : 1'bz;

  i2c_master_writer #(.SLAVE_ADDR(ADDR), .CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .rst(rst), .start(start), .data_in(dataIn),
    .busy(busy), .done(done), .ack_err(ackErr),
    .i2c_scl(sclW), .i2c_sda(sdaW)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // The SCL rise inside STOP is not a data clock, so it is dropped when the frame closes.
  always @(negedge clk) begin
    if (rst) begin
      bitRises = 0; curWord = 64'd0; curLen = 0; pull = 1'b0; inFrame = 1'b0;
    end else begin
      if (prevScl && sclW && prevSda && !sdaW) begin
        if (inFrame) overlapCount++;
        inFrame = 1'b1; startCount++; bitRises = 0; curWord = 64'd0; curLen = 0;
      end
      if (prevScl && sclW && !prevSda && sdaW && inFrame) begin
        lastWord = curWord >> 1; lastLen = curLen - 1; frameCount++; inFrame = 1'b0;
      end
      if (!prevScl && sclW) begin
        curWord = {curWord[62:0], sdaW}; curLen++; bitRises++;
      end
      if (prevScl && !sclW)
        pull = (bitRises == 8 && ack1En) || (bitRises == 41 && ack2En);
      if (done) doneCount++;
      if (busy && !prevBusy) busyRiseCyc = cyc;
    end
    prevScl = sclW; prevSda = sdaW; prevBusy = busy;
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nVec++;
    assert (obs === exp) else begin
      nErr++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] word, output int accCyc);
    @(negedge clk);
    checkOutput("idle_before_start", 64'(busy), 64'd0);
    start = 1'b1; dataIn = word; accCyc = cyc;
    @(negedge clk);
    start = 1'b0;
    checkOutput("busy_after_accept", 64'(busy), 64'd1);
    checkOutput("ack_err_cleared", 64'(ackErr), 64'd0);
  endtask

  task automatic waitDone(output int doneCyc, output bit timedOut);
    timedOut = 1'b1; doneCyc = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (done) begin doneCyc = cyc; timedOut = 1'b0; break; end
    end
  endtask

  task automatic waitRises(input int n);
    bit to = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      #1;
      if (bitRises >= n) begin to = 1'b0; break; end
    end
    checkOutput("rise_wait_timeout", 64'(to), 64'd0);
  endtask

  // Reference model: frame bits and timing follow directly from the protocol description.
  task automatic expectFrame(input logic [31:0] word, input bit a1, input bit a2,
                             output logic [63:0] expWord, output int expLen,
                             output int expLat, output bit expErr);
    if (a1) begin
      expWord = {22'd0, ADDR, 1'b0, 1'b0, word, ~a2}; expLen = 42;
      expLat = LAT_FULL; expErr = ~a2;
    end else begin
      expWord = {55'd0, ADDR, 1'b0, 1'b1}; expLen = 9;
      expLat = LAT_ABRT; expErr = 1'b1;
    end
  endtask

  task automatic runTxn(input string name, input logic [31:0] word, input bit a1, input bit a2);
    int acc, dc, f0, d0, expLen, expLat;
    bit to, expErr;
    logic [63:0] expWord;
    ack1En = a1; ack2En = a2;
    f0 = frameCount; d0 = doneCount;
    expectFrame(word, a1, a2, expWord, expLen, expLat, expErr);
    applyStimulus(word, acc);
    waitDone(dc, to);
    checkOutput({name, "_timeout"}, 64'(to), 64'd0);
    checkOutput({name, "_latency"}, 64'(dc - acc), 64'(expLat));
    checkOutput({name, "_ack_err"}, 64'(ackErr), 64'(expErr));
    checkOutput({name, "_busy_at_done"}, 64'(busy), 64'd0);
    repeat (4) @(negedge clk);
    #1;
    checkOutput({name, "_ack_err_held"}, 64'(ackErr), 64'(expErr));
    checkOutput({name, "_frames"}, 64'(frameCount - f0), 64'd1);
    checkOutput({name, "_dones"}, 64'(doneCount - d0), 64'd1);
    checkOutput({name, "_bit_count"}, 64'(lastLen), 64'(expLen));
    checkOutput({name, "_bits"}, lastWord, expWord);
  endtask

  initial begin
    int acc, dc1, dc2, f0, s0, d0, o0;
    bit to;
    logic [31:0] w;

    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_ack_err", 64'(ackErr), 64'd0);
    checkOutput("rst_scl", 64'(sclW), 64'd1);
    checkOutput("rst_sda", 64'(sdaW), 64'd1);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    $display("[TB] nominal write");
    runTxn("nominal", 32'hDEADBEEF, 1'b1, 1'b1);
    $display("[TB] address NACK");
    runTxn("addr_nack", $urandom, 1'b0, 1'b1);
    $display("[TB] data NACK");
    runTxn("data_nack", $urandom, 1'b1, 1'b0);

    $display("[TB] busy protection");
    w = $urandom;
    ack1En = 1'b1; ack2En = 1'b1;
    f0 = frameCount; s0 = startCount; d0 = doneCount;
    applyStimulus(w, acc);
    waitRises(25);
    start = 1'b1; dataIn = 32'h12345678;
    repeat (3) @(negedge clk);
    start = 1'b0;
    waitDone(dc1, to);
    checkOutput("busyprot_timeout", 64'(to), 64'd0);
    checkOutput("busyprot_latency", 64'(dc1 - acc), 64'(LAT_FULL));
    repeat (20) @(negedge clk);
    #1;
    checkOutput("busyprot_starts", 64'(startCount - s0), 64'd1);
    checkOutput("busyprot_dones", 64'(doneCount - d0), 64'd1);
    checkOutput("busyprot_frames", 64'(frameCount - f0), 64'd1);
    checkOutput("busyprot_bits", lastWord, {22'd0, ADDR, 1'b0, 1'b0, w, 1'b0});

    $display("[TB] reset mid-data");
    applyStimulus(32'hCAFEF00D, acc);
    waitRises(20);
    rst = 1'b1;
    #1;
    checkOutput("midrst_scl", 64'(sclW), 64'd1);
    checkOutput("midrst_sda", 64'(sdaW), 64'd1);
    checkOutput("midrst_busy", 64'(busy), 64'd0);
    checkOutput("midrst_done", 64'(done), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    runTxn("post_reset", 32'h00000001, 1'b1, 1'b1);

    $display("[TB] back-to-back");
    ack1En = 1'b1; ack2En = 1'b1;
    f0 = frameCount; s0 = startCount; o0 = overlapCount;
    @(negedge clk);
    start = 1'b1; dataIn = 32'hA5A5A5A5; acc = cyc;
    waitDone(dc1, to);
    checkOutput("b2b_first_timeout", 64'(to), 64'd0);
    checkOutput("b2b_first_latency", 64'(dc1 - acc), 64'(LAT_FULL));
    @(negedge clk);
    #1;
    start = 1'b0;
    checkOutput("b2b_busy_again", 64'(busy), 64'd1);
    checkOutput("b2b_busy_rise_cycle", 64'(busyRiseCyc), 64'(dc1 + 1));
    waitDone(dc2, to);
    checkOutput("b2b_second_timeout", 64'(to), 64'd0);
    checkOutput("b2b_second_latency", 64'(dc2 - dc1), 64'(LAT_FULL));
    repeat (10) @(negedge clk);
    #1;
    checkOutput("b2b_frames", 64'(frameCount - f0), 64'd2);
    checkOutput("b2b_starts", 64'(startCount - s0), 64'd2);
    checkOutput("b2b_stop_between", 64'(overlapCount - o0), 64'd0);
    checkOutput("b2b_bits", lastWord, {22'd0, ADDR, 1'b0, 1'b0, 32'hA5A5A5A5, 1'b0});

    $display("[TB] random transactions");
    for (int k = 0; k < 4; k++) begin
      bit a1, a2;
      a1 = ($urandom_range(0, 3) != 0);
      a2 = 1'($urandom_range(0, 1));
      runTxn("random", $urandom, a1, a2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule

// File: doc/i2c_master_writer.md
# i2c_master_writer

Single-transaction I2C write master that feeds the team's 32-bit I2C slave receiver. On a start request it issues START, a 7-bit slave address with R/W=0, samples the slave ACK, shifts 32 data bits MSB-first with no per-byte ACK, samples a final ACK, and issues STOP. It sits directly upstream of the slave controller on the shared open-drain SDA/SCL pair and reports completion and ACK errors to local control logic.

## Interface
- `SLAVE_ADDR`, default 7'b0101010: target address, sent MSB-first.
- `CLK_DIV`, default 250: `clk` cycles per SCL quarter-period. Minimum is 2. The SCL period is 4*CLK_DIV.
- `clk` in, 1 bit: the only clock. All logic is on its rising edge.
- `rst` in, 1 bit: asynchronous, active-high reset.
- `start` in, 1 bit: transaction request. Sampled only while `busy`=0.
- `data_in` in, 32 bits: payload. Captured in the cycle `start` is accepted.
- `busy` out, 1 bit: high from the cycle after acceptance through the cycle before `done`.
- `done` out, 1 bit: one-cycle pulse at the end of every transaction, including aborted ones.
- `ack_err` out, 1 bit: NACK seen in the last transaction. Valid with `done` and held until the next acceptance.
- `i2c_scl` inout, 1 bit: open-drain. Drives 0 or z, never 1.
- `i2c_sda` inout, 1 bit: open-drain. Drives 0 or z. Read through a 2-flop synchronizer.

## Operation
- States are IDLE, START, ADDR, ACK1, DATA, ACK2, STOP, DONE.
- The quarter counter counts CLK_DIV cycles per quarter. The bit counter is 6 bits.
- **IDLE**
  - SCL and SDA are released.
  - When `start`=1, capture `data_in`, clear `ack_err`, and go to START.
- **START** (2 quarters)
  - SCL released throughout.
  - SDA pulled low at entry, producing a falling SDA while SCL is high.
- **Bit slot** (4 quarters, used by every bit state)
  - q0: SCL low; update SDA at q0 entry.
  - q1: SCL low.
  - q2: SCL released (high).
  - q3: SCL released (high).
  - SDA never changes while SCL is high, except in START and STOP.
- **ADDR**: 8 slots carrying SLAVE_ADDR[6:0] and then 0 (R/W=write). Transmitted 0 means SDA driven low; transmitted 1 means SDA released.
- **ACK1**: SDA released for 1 slot. Sample the synchronized SDA on the last `clk` of q3.
  - 0 goes to DATA.
  - 1 sets `ack_err` and goes to STOP; no data is sent.
- **DATA**: 32 slots, captured word bit 31 down to bit 0.
- **ACK2**: same as ACK1. A 1 sets `ack_err`. Both outcomes go to STOP.
- **STOP** (4 quarters)
  - q0: SCL low, SDA low.
  - q1: SCL released, SDA low.
  - q2: SDA released (rising while SCL is high).
  - q3: bus idle.
- **DONE**: pulse `done` for one cycle, then return to IDLE.
- A full transaction has 42 SCL rising edges (8+1+32+1). The slave samples on SCL rising and drives ACK after SCL falling, which this schedule satisfies.
- Clock stretching and arbitration are not supported; SCL is never read back.

## Timing
- Reset values, applied immediately and asynchronously:
  - `busy`=0, `done`=0, `ack_err`=0.
  - SCL and SDA released.
  - State IDLE, counters 0, captured data 0.
- Acceptance is cycle A, where `start`=1 and `busy`=0. `busy` rises at A+1.
- Full transaction: 2+168+4 = 174 quarters. `done` is high at A+1+174*CLK_DIV, and `busy` is low in that same cycle.
- ACK1 abort: 2+36+4 = 42 quarters. `done` is high at A+1+42*CLK_DIV.
- `done` lies within IDLE-eligible timing: `start` high in the `done` cycle is accepted, so back-to-back transactions are allowed.
- `start` and `data_in` changes while `busy`=1 are ignored.
- Reset asserted mid-transaction: the lines are released within the same cycle and no STOP is generated. Slave-side recovery is a system-level concern.
- SDA sample point is the last `clk` of q3. The synchronizer latency of 2 cycles is covered because CLK_DIV ≥ 2.

## Test plan
- **Nominal write.** CLK_DIV=2, `data_in`=32'hDEADBEEF, bus model ACKs both slots.
  - Address bits on the bus: 0101010_0.
  - Data bits on the bus: DEADBEEF MSB-first.
  - `done` at A+349, `ack_err`=0.
  - Attached slave receiver shows `dataout`=DEADBEEF and `rx_done`=1.
- **Address NACK.** Model leaves SDA high in ACK1.
  - No data clocks; STOP issued.
  - `done` at A+1+84, `ack_err`=1.
  - Exactly 9 SCL rising edges.
- **Data NACK.** Model ACKs ACK1 only.
  - Full 42 SCL rising edges.
  - `done` at A+349, `ack_err`=1.
- **Busy protection.** Pulse `start` and change `data_in` to 0x12345678 mid-DATA.
  - No second START.
  - Bus still carries the originally captured word.
  - Exactly one `done`.
- **Reset mid-DATA.** Assert `rst` at bit 10.
  - SCL and SDA are z in the same cycle; `busy`=0, `done`=0.
  - After release and a fresh slave model, a 0x00000001 transaction completes normally.
- **Back-to-back.** Hold `start`=1 continuously with 0xA5A5A5A5.
  - Second `busy` rise occurs the cycle after the first `done`.
  - Two complete frames, each with a STOP before the next START.
